// File: rtl/scpu_pkg.sv
// ============================================================================
// Module      : scpu_pkg
// Description : Shared SCPU types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2
  } ifu_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC select (jump > taken branch > pc+4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc (
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_inst_idx,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_jump_tgt;
  logic [31:0] w_branch_tgt;

  assign w_jump_tgt   = {i_pc_plus4[31:28], i_inst_idx, 2'b00};
  // The branch immediate is the low half of the jump index field.
  assign w_branch_tgt = i_pc_plus4 + {{14{i_inst_idx[15]}}, i_inst_idx[15:0], 2'b00};

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_tgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_branch_tgt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module      : inst_fetch_unit
// Description : SCPU fetch stage - PC/IR, imem handshake, next-PC, timeout flag.
//               Optional retire counter enabled by macro IFU_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
  import scpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        cpu_stall,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  fun,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic [31:0] inst_count
);

  localparam logic [31:0] c_wait_limit = 32'(WAIT_LIMIT);

  ifu_state_t  r_state;
  ifu_state_t  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_wait_cnt;
  logic        r_fetch_err;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic [31:0] w_cnt_inc;
  logic        w_capture;
  logic        w_retire;
  logic        w_wait_tick;
  logic        w_limit_hit;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_calc u_next_pc_calc (
    .i_pc_plus4 (w_pc_plus4),
    .i_inst_idx (r_inst[25:0]),
    .i_branch   (branch),
    .i_jump     (jump),
    .i_zero     (zero),
    .o_next_pc  (w_next_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_wait_tick = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_wait_tick = 1'b1;
        end
      end
      S_EXEC: begin
        if (!cpu_stall) begin
          w_retire    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign w_cnt_inc   = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 32'd1;
  // Flag on the cycle the counter arrives at the limit, not one later.
  assign w_limit_hit = (c_wait_limit != 32'd0) && (w_cnt_inc >= c_wait_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_inst      <= NOP_WORD;
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_inst     <= imem_rdata;
        r_wait_cnt <= '0;
      end else if (w_wait_tick) begin
        r_wait_cnt <= w_cnt_inc;
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
      end
      if (w_wait_tick && w_limit_hit) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] r_inst_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_count <= '0;
    end else if (w_retire) begin
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign inst_count = r_inst_count;
`else
  assign inst_count = 32'h0;
`endif

  // Request is gated by rst_n so it drops the instant reset asserts.
  assign imem_req   = rst_n && (r_state != S_EXEC);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == S_EXEC);
  assign inst       = r_inst;
  assign opcode     = r_inst[31:26];
  assign fun        = r_inst[5:0];
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign fetch_err  = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed self-checking bench for inst_fetch_unit (WAIT_LIMIT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;
  import scpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic        cpu_stall = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [5:0]  fun;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic [31:0] inst_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_count;

  localparam logic [31:0] W_ADD    = 32'h0022_1820;
  localparam logic [31:0] W_BEQ    = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
  localparam logic [31:0] W_J_MAX  = {OP_J, 26'h3FF_FFFF};
  localparam logic [31:0] W_J_ZERO = {OP_J, 26'h000_0000};
  localparam logic [31:0] W_J_40   = {OP_J, 26'h000_0040};

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_LIMIT (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .cpu_stall  (cpu_stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .opcode     (opcode),
    .fun        (fun),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef IFU_RETIRE_CNT_EN
    return m_count;
`else
    return 32'h0;
`endif
  endfunction

  // Entered just after a negedge with the DUT in S_REQ.
  task automatic fetch(input logic [31:0] word, input int waits);
    int          n;
    logic [31:0] ea;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_asserted", 32'(imem_req), 32'd1);
    ea = (q_addr.size() > 0) ? q_addr.pop_front() : 32'hxxxx_xxxx;
    chk("fetch_addr", imem_addr, ea);
    chk("req_valid_low", 32'(inst_valid), 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, ea);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    q_inst.push_back(word);
    @(negedge clk);
    imem_ready = 1'b0;
    m_inst = (q_inst.size() > 0) ? q_inst.pop_front() : 32'hxxxx_xxxx;
    m_pc   = ea;
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("inst", inst, m_inst);
    chk("opcode", 32'(opcode), 32'(m_inst[31:26]));
    chk("fun", 32'(fun), 32'(m_inst[5:0]));
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
  endtask

  // Entered in S_EXEC; memory is driven with junk to show it is ignored.
  task automatic exec(input logic b, input logic j, input logic z, input int stall,
                      input logic [31:0] exp_next);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    branch = b;
    jump   = j;
    zero   = z;
    cpu_stall = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, m_inst);
      chk("stall_pc", pc, m_pc);
      chk("stall_count", inst_count, exp_count());
    end
    cpu_stall = 1'b0;
    q_addr.push_back(exp_next);
    m_count = m_count + 32'd1;
    @(negedge clk);
    branch = 1'b0;
    jump   = 1'b0;
    zero   = 1'b0;
    imem_ready = 1'b0;
    chk("retire_valid", 32'(inst_valid), 32'd0);
    chk("retire_count", inst_count, exp_count());
  endtask

  initial begin
    m_count = '0;
    m_pc    = '0;
    m_inst  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_count", inst_count, 32'h0);
    rst_n = 1'b1;
    q_addr.push_back(32'h0);

    // Back-to-back fetches with zero wait
    fetch(W_ADD, 0);  exec(1'b0, 1'b0, 1'b0, 0, 32'h0000_0004);
    fetch(32'h8C41_0008, 0); exec(1'b0, 1'b0, 1'b1, 0, 32'h0000_0008);
    fetch(32'h2841_0005, 0); exec(1'b1, 1'b0, 1'b0, 0, 32'h0000_000C);
    fetch(32'hAC41_0010, 0); exec(1'b0, 1'b0, 1'b0, 0, 32'h0000_0010);

    // beq backward taken, then not taken
    fetch(W_BEQ, 0);  exec(1'b1, 1'b0, 1'b1, 0, 32'h0000_000C);
    fetch(W_ADD, 2);
    chk("err_below_limit", 32'(fetch_err), 32'd0);
    exec(1'b0, 1'b0, 1'b0, 0, 32'h0000_0010);
    fetch(W_BEQ, 0);  exec(1'b1, 1'b0, 1'b0, 0, 32'h0000_0014);

    // Three wait cycles reach WAIT_LIMIT=2
    fetch(W_J_MAX, 3);
    chk("err_set", 32'(fetch_err), 32'd1);
    exec(1'b0, 1'b1, 1'b0, 0, 32'h0FFF_FFFC);
    fetch(W_J_ZERO, 0);
    chk("err_sticky", 32'(fetch_err), 32'd1);
    exec(1'b0, 1'b1, 1'b0, 0, 32'h1000_0000);

    // jump and branch together: jump wins
    fetch(W_J_40, 0); exec(1'b1, 1'b1, 1'b1, 0, 32'h1000_0100);

    // Stall holds the instruction for five cycles
    fetch(W_J_MAX, 0); exec(1'b0, 1'b1, 1'b0, 5, 32'h1FFF_FFFC);

    // Climb the top nibble to reach the wrap point
    for (int n = 1; n < 15; n++) begin
      fetch(W_J_MAX, 0);
      exec(1'b0, 1'b1, 1'b0, 0, {4'(n + 1), 28'hFFF_FFFC});
    end
    fetch(W_ADD, 0);  exec(1'b0, 1'b0, 1'b0, 0, 32'h0000_0000);
    fetch(W_ADD, 0);  exec(1'b0, 1'b0, 1'b0, 0, 32'h0000_0004);

    // Reset asserted while waiting on memory
    imem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h0000_0004);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_pc", pc, 32'h0);
    chk("async_inst", inst, 32'h0);
    chk("async_err", 32'(fetch_err), 32'd0);
    chk("async_valid", 32'(inst_valid), 32'd0);
    chk("async_count", inst_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    q_addr.delete();
    q_addr.push_back(32'h0);
    m_count = '0;
    fetch(W_BEQ, 0);  exec(1'b0, 1'b0, 1'b1, 0, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
